// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; stalls the front end while busy.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] RS_IN,
    input  logic [WIDTH-1:0] RT_IN,
    input  logic             Wr_HI,
    input  logic             Wr_LO,
    input  logic [WIDTH-1:0] WData,
    input  logic             Flush,
    output logic [WIDTH-1:0] HI_OUT,
    output logic [WIDTH-1:0] LO_OUT,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    logic               rs_neg_s, rt_neg_s, last_s;
    logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH+1:0]   diff_s;
    logic [2*WIDTH-1:0] psum_s;

    // Operand magnitudes and one restoring-divide / shift-add step
    always_comb begin
        rs_neg_s = Op[0] & RS_IN[WIDTH-1];
        rt_neg_s = Op[0] & RT_IN[WIDTH-1];
        rs_mag_s = rs_neg_s ? neg_w(RS_IN) : RS_IN;
        rt_mag_s = rt_neg_s ? neg_w(RT_IN) : RT_IN;
        rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, b_q[WIDTH-1:0]};
        psum_s   = acc_q + (m_q[0] ? b_q : {(2*WIDTH){1'b0}});
`ifdef MULDIV_EARLY_OUT_EN
        last_s   = (cnt_q == CW'(1)) | (~op_q[1] & (m_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
`else
        last_s   = (cnt_q == CW'(1));
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        b_d     = b_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    op_d   = Op;
                    neg_d  = rs_neg_s ^ rt_neg_s;
                    rneg_d = rs_neg_s;
                    cnt_d  = CW'(WIDTH);
                    if (Op[1] && (RT_IN == {WIDTH{1'b0}})) begin
                        hi_d    = RS_IN;
                        lo_d    = {WIDTH{1'b1}};
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (Op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, rs_mag_s};
                        b_d     = {{WIDTH{1'b0}}, rt_mag_s};
                        m_d     = {WIDTH{1'b0}};
                        state_d = S_CALC;
                    end else begin
                        acc_d   = {(2*WIDTH){1'b0}};
                        b_d     = {{WIDTH{1'b0}}, rs_mag_s};
                        m_d     = rt_mag_s;
                        state_d = S_CALC;
                    end
                end else begin
                    hi_d = Wr_HI ? WData : hi_q;
                    lo_d = Wr_LO ? WData : lo_q;
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (op_q[1]) begin
                        // Borrow out means the trial subtract failed: restore the shifted remainder
                        acc_d = diff_s[WIDTH+1] ? {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                                : {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = psum_s;
                        b_d   = {b_q[2*WIDTH-2:0], 1'b0};
                        m_d   = {1'b0, m_q[WIDTH-1:1]};
                    end
                    state_d = last_s ? S_FIX : S_CALC;
                end
            end
            S_FIX: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (op_q[1]) begin
                    lo_d    = neg_q  ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    hi_d    = rneg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end else begin
                    {hi_d, lo_d} = neg_q ? neg_2w(acc_q) : acc_q;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 2'b00;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= {(2*WIDTH){1'b0}};
            b_q     <= {(2*WIDTH){1'b0}};
            m_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign HI_OUT  = hi_q;
    assign LO_OUT  = lo_q;
    assign Done    = (state_q == S_DONE);
    assign DivZero = dz_q;
    assign Busy    = (state_q == S_CALC) | (state_q == S_FIX) | ((state_q == S_IDLE) & Start);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_ex_muldiv_unit;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] RS_IN = 32'h0;
    logic [31:0] RT_IN = 32'h0;
    logic        Wr_HI = 1'b0;
    logic        Wr_LO = 1'b0;
    logic [31:0] WData = 32'h0;
    logic        Flush = 1'b0;
    logic [31:0] HI_OUT, LO_OUT;
    logic        Busy, Done, DivZero;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .RS_IN(RS_IN), .RT_IN(RT_IN),
        .Wr_HI(Wr_HI), .Wr_LO(Wr_LO), .WData(WData), .Flush(Flush),
        .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [31:0] x);
        int n = 0;
        for (int i = 0; i < 32; i++) if (x[i]) n = i + 1;
        return n;
    endfunction

    // Reference: architectural result straight from signed/unsigned arithmetic
    task automatic model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                         output int lat);
        logic [63:0] p;
        longint a, b, q, r;
        logic [31:0] mag;
        dz = 1'b0;
        case (op)
            2'd0: begin p = {32'h0, rs} * {32'h0, rt}; {hi, lo} = p; end
            2'd1: begin a = $signed(rs); b = $signed(rt); p = a * b; {hi, lo} = p; end
            default: begin
                if (rt == 32'h0) begin
                    hi = rs; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (op == 2'd2) begin
                    lo = rs / rt; hi = rs % rt;
                end else begin
                    a = $signed(rs); b = $signed(rt); q = a / b; r = a % b;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
        endcase
        lat = 34;
        if (dz) lat = 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (op == 2'd0) lat = ((bitlen(rt) > 1) ? bitlen(rt) : 1) + 2;
        if (op == 2'd1) begin
            mag = rt[31] ? (~rt + 32'd1) : rt;
            lat = ((bitlen(mag) > 1) ? bitlen(mag) : 1) + 2;
        end
`endif
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt);
        logic [31:0] ehi, elo;
        logic        edz, busy_ok;
        int          elat, cyc;
        model(op, rs, rt, ehi, elo, edz, elat);
        @(negedge Clk);
        Start = 1'b1; Op = op; RS_IN = rs; RT_IN = rt;
        #1 chk({tag, ".busy0"}, {63'h0, Busy}, 64'h1);
        @(negedge Clk);
        Start = 1'b0; RS_IN = $urandom; RT_IN = $urandom; Op = 2'($urandom);
        cyc = 1; busy_ok = 1'b1;
        #1;
        while (Done !== 1'b1 && cyc < 120) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(negedge Clk); #1; cyc++;
        end
        chk({tag, ".lat"}, 64'(cyc), 64'(elat));
        chk({tag, ".busy_run"}, {63'h0, busy_ok}, 64'h1);
        chk({tag, ".busy_done"}, {63'h0, Busy}, 64'h0);
        chk({tag, ".hi"}, {32'h0, HI_OUT}, {32'h0, ehi});
        chk({tag, ".lo"}, {32'h0, LO_OUT}, {32'h0, elo});
        chk({tag, ".dz"}, {63'h0, DivZero}, {63'h0, edz});
        @(negedge Clk);
        #1 chk({tag, ".done_pulse"}, {63'h0, Done}, 64'h0);
    endtask

    task automatic mt(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge Clk);
        Wr_HI = whi; Wr_LO = wlo; WData = d;
        @(negedge Clk);
        Wr_HI = 1'b0; Wr_LO = 1'b0; WData = 32'h0;
    endtask

    initial begin
        logic        saw_done;
        logic [1:0]  rop;
        logic [31:0] rrs, rrt;

        repeat (3) @(negedge Clk);
        chk("reset.hi", {32'h0, HI_OUT}, 64'h0);
        chk("reset.lo", {32'h0, LO_OUT}, 64'h0);
        chk("reset.ctl", {61'h0, Busy, Done, DivZero}, 64'h0);
        Rst_n = 1'b1;

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.hi_const", {32'h0, HI_OUT}, 64'hFFFF_FFFE);

        // Asynchronous reset at cycle 10 of a multiply
        @(negedge Clk);
        Start = 1'b1; Op = 2'd0; RS_IN = 32'd3; RT_IN = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", {63'h0, Busy}, 64'h0);
        chk("rst_mid.hilo", {HI_OUT, LO_OUT}, 64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin @(negedge Clk); #1 if (Done === 1'b1) saw_done = 1'b1; end
        chk("rst_mid.no_done", {63'h0, saw_done}, 64'h0);

        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg.lo_const", {32'h0, LO_OUT}, 64'hFFFF_FFEB);
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg.lo_const", {HI_OUT, LO_OUT}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'd2, 32'd100, 32'd7);
        chk("divu.const", {HI_OUT, LO_OUT}, {32'd2, 32'd14});
        run_op("divu_zero", 2'd2, 32'd100, 32'd0);
        run_op("div_zero", 2'd3, 32'h8000_0000, 32'd0);
        run_op("div_wrap", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_wrap.const", {HI_OUT, LO_OUT}, 64'h0000_0000_8000_0000);
        run_op("mult_minneg", 2'd1, 32'h8000_0000, 32'h8000_0000);

        // Register writes, then a flushed multiply with ignored Start and strobes
        mt(1'b1, 1'b1, 32'hA5A5_0F0F);
        chk("mt_both", {HI_OUT, LO_OUT}, 64'hA5A5_0F0F_A5A5_0F0F);
        mt(1'b1, 1'b0, 32'h1234_5678);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        chk("mt_each", {HI_OUT, LO_OUT}, 64'h1234_5678_CAFE_F00D);
        @(negedge Clk);
        Start = 1'b1; Op = 2'd0; RS_IN = 32'd5; RT_IN = 32'd6; Wr_LO = 1'b1; WData = 32'h0000_DEAD;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            Start = (i == 5); RS_IN = (i == 5) ? 32'd9 : 32'd5;
            Wr_LO = 1'b0; Wr_HI = (i == 8); WData = (i == 8) ? 32'h0000_0BAD : 32'h0;
            Flush = (i == 12);
        end
        @(negedge Clk);
        Flush = 1'b0;
        #1 chk("flush.busy", {63'h0, Busy}, 64'h0);
        saw_done = 1'b0;
        repeat (40) begin @(negedge Clk); #1 if (Done === 1'b1) saw_done = 1'b1; end
        chk("flush.no_done", {63'h0, saw_done}, 64'h0);
        chk("flush.hilo", {HI_OUT, LO_OUT}, 64'h1234_5678_CAFE_F00D);
        run_op("multu_fresh", 2'd0, 32'd5, 32'd6);
        chk("multu_fresh.const", {HI_OUT, LO_OUT}, 64'd30);

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            rrs = $urandom;
            case ($urandom_range(0, 5))
                0:       rrt = 32'h0;
                1:       rrt = 32'($urandom_range(1, 255));
                2:       rrt = ~32'($urandom_range(0, 15));
                default: rrt = $urandom;
            endcase
            run_op("rand", rop, rrs, rrt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the rs/rt operand values and the muldiv opcode that ID/EX presents.
- Owns the architectural HI/LO registers and asserts Busy to stall the IF/ID/EX front end while an operation is in flight.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.

Parameters:
- WIDTH, 32, operand/register width; must be even and >= 4.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  issue a muldiv op; sampled only in IDLE.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- RS_IN  in  WIDTH  multiplicand / dividend.
- RT_IN  in  WIDTH  multiplier / divisor.
- Wr_HI  in  1  MTHI write strobe.
- Wr_LO  in  1  MTLO write strobe.
- WData  in  WIDTH  MTHI/MTLO data.
- Flush  in  1  abort the in-flight op (branch or exception squash).
- HI_OUT  out  WIDTH  HI register.
- LO_OUT  out  WIDTH  LO register.
- Busy  out  1  stall request to the pipeline.
- Done  out  1  one-cycle pulse; HI/LO hold the new result.
- DivZero  out  1  pulses together with Done when a divide had RT_IN == 0.

Behaviour:
- Reset (async, Rst_n = 0):
  - state = IDLE.
  - HI_OUT, LO_OUT, counter and working registers = 0.
  - Busy, Done and DivZero = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Start = 1: latch operand magnitudes and sign flags, go to CALC, load counter with WIDTH.
  - Exception: divide with RT_IN == 0 goes straight to DONE, writing HI = RS_IN and LO = all-ones; DivZero = 1 during that DONE cycle.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - Counter decrements; at 1, go to FIX.
- FIX: apply signs for signed ops, write HI/LO, go to DONE.
  - MULT: 2*WIDTH product negated if operand signs differ.
  - DIV: quotient (LO) negated if signs differ; remainder (HI) takes the sign of the dividend.
  - Unsigned ops: no correction.
  - HI = product upper half or remainder; LO = product lower half or quotient.
- DONE: Done = 1 for exactly one cycle, then IDLE.
- Latency: Start in cycle 0 gives Done in cycle WIDTH+2 (34 for WIDTH=32). Divide-by-zero gives Done in cycle 1.
- Busy is combinational: (state == CALC) | (state == FIX) | (state == IDLE & Start).
  - Busy is low in the DONE cycle, so the stalled instruction advances together with Done.
- Start outside IDLE: ignored.
- Wr_HI / Wr_LO:
  - Take effect only in IDLE with Start = 0; the write is visible on the next edge.
  - Both strobes together write both registers.
  - Ignored in every other state, and ignored when Start = 1 in the same cycle.
- Flush:
  - In CALC or FIX: next state is IDLE; HI/LO unchanged; no Done.
  - In DONE: no effect, because HI/LO were already written.
  - In IDLE with Start: Start is suppressed.
  - Flush has priority over every other input.
- Most-negative dividend / -1 (DIV): the result wraps; LO = most-negative value, HI = 0. No trap.
- Operands are captured at issue; RS_IN/RT_IN changes after the issue cycle have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply ops leave CALC at the end of any CALC cycle after which the remaining multiplier bits are all zero, or when the counter expires, whichever comes first.
  - CALC lasts max(1, bitlen(|RT_IN|)) cycles.
  - Done arrives in cycle CALC+2.
  - Results are identical to the non-early-out path.
  - Divide latency is unchanged.
- Undefined: every multiply takes the full WIDTH CALC cycles.

Test Plan:
- Reset mid-CALC: assert Rst_n = 0 asynchronously at cycle 10 of a MULTU -> state IDLE, HI/LO = 0, Busy = 0 immediately, no Done afterwards.
- MULTU RS = 0xFFFFFFFF, RT = 0xFFFFFFFF -> Done in cycle 34; HI = 0xFFFFFFFE, LO = 0x00000001; Busy high in cycles 0-33, low in cycle 34.
- MULT RS = 0xFFFFFFFD (-3), RT = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - With MULDIV_EARLY_OUT_EN defined: Done in cycle 5.
- DIV RS = 0xFFFFFFF9 (-7), RT = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU RS = 100, RT = 7 -> LO = 14, HI = 2.
- DIVU RS = 100, RT = 0 -> Done and DivZero in cycle 1; HI = 100, LO = 0xFFFFFFFF.
- MTHI 0x12345678, then MULTU 5 x 6 with Flush at cycle 12 -> no Done; HI = 0x12345678 and LO unchanged.
  - A Start issued during the flushed op is ignored.
  - A fresh MULTU 5 x 6 afterwards gives LO = 30, HI = 0.
